uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Downstream consumer of the UART receiver. Runs the receiver's 4-phase ready/ack handshake and buffers received bytes in a synchronous FIFO.
- Presents a show-ahead read port, plus empty/full/count/overrun status, to the serial-port I/O register logic on the CPU side.
- Lives in the i_uart_clk_x16 domain, the same clock as the receiver, so no CDC is needed on the handshake.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 bytes).

Ports:
- i_uart_clk_x16  in  1  block clock, shared with the receiver.
- i_reset_n  in  1  reset, synchronous active-low.
- i_rx_data  in  8  byte from the receiver; valid while i_rx_data_rdy=1.
- i_rx_data_rdy  in  1  receiver has a byte.
- o_rx_rdy_ack  out  1  ack to the receiver; registered.
- i_rx_rdy_ack_clr  in  1  receiver's ack-clear acknowledge.
- i_rd_strobe  in  1  single-cycle pop request.
- o_rd_data  out  8  FIFO head (show-ahead); value is don't-care when empty.
- o_empty  out  1  FIFO empty.
- o_full  out  1  FIFO full.
- o_count  out  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
- o_overrun  out  1  sticky flag: a byte was dropped.
- i_overrun_clr  in  1  clears o_overrun.

Behaviour:
- Reset is only sampled at a clock edge and is synchronous active-low. When i_reset_n=0 at an edge:
  - state=IDLE, rd/wr pointers=0, o_count=0, o_empty=1, o_full=0, o_overrun=0, o_rx_rdy_ack=0.
  - FIFO RAM contents are not cleared.
- Handshake FSM, three states:
  - IDLE: on i_rx_data_rdy=1 && i_rx_rdy_ack_clr=0, capture i_rx_data (push, or drop if full), set o_rx_rdy_ack=1, go to ACK.
  - ACK: hold o_rx_rdy_ack=1 until i_rx_rdy_ack_clr=1, then set o_rx_rdy_ack=0 and go to WAIT_CLR.
  - WAIT_CLR: wait until i_rx_rdy_ack_clr=0, then go to IDLE.
- Exactly one capture per byte. i_rx_data_rdy still seen high in ACK or WAIT_CLR is ignored.
- Receiver reset mid-handshake: it drops ack_clr, then re-raises it while our ack is high. The FSM therefore completes with no deadlock and no timeout logic.
- Push latency: a byte captured at edge N shows o_empty=0, o_count+1 and o_rd_data=byte after edge N.
- Pop:
  - i_rd_strobe=1 with o_empty=0 advances the read pointer at the edge; the next byte appears after that edge.
  - Pop on empty is ignored: no pointer change, no flag.
- Full:
  - A capture with o_full=1 and no same-cycle pop drops the byte and sets o_overrun=1.
  - The handshake still completes normally.
- Simultaneous capture and pop:
  - Both take effect; o_count is unchanged.
  - If the FIFO was full, the byte is accepted (no overrun).
  - If the FIFO was empty, the pop is ignored and the push is accepted.
- Overrun flag: i_overrun_clr clears o_overrun. A same-cycle drop wins, so the flag stays 1.
- Pointers and arithmetic:
  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - o_count is maintained as a separate counter.
  - o_empty = (o_count==0); o_full = (o_count==DEPTH). Both are registered or derived from the registered count.
- RAM: write synchronous, read asynchronous from the read pointer (show-ahead).

Test Plan:
- Reset then single byte:
  - Stimulus: hold i_reset_n=0 for 2 cycles, release, receiver delivers 0xA5.
  - Required: o_rx_rdy_ack rises 1 cycle after i_rx_data_rdy, falls 1 cycle after i_rx_rdy_ack_clr; o_empty=0, o_count=1, o_rd_data=0xA5; one pop then gives o_empty=1.
- Ordering and wrap:
  - Stimulus: push 40 bytes 0x00..0x27, popping each one 3 cycles after arrival.
  - Required: reads return 0x00..0x27 in order across pointer wrap; o_count never exceeds 1; o_overrun=0.
- Fill and overrun:
  - Stimulus: push 17 bytes 0x10..0x20 with no pops.
  - Required: o_full=1 and o_count=16 after the 16th byte; 17th byte (0x20) dropped; o_overrun=1; draining returns 0x10..0x1F.
- Overrun clear race:
  - Stimulus: with FIFO full, assert i_overrun_clr in the same cycle as a dropped capture.
  - Required: o_overrun=1. Clear again on a later idle cycle: o_overrun=0.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full with head 0x10, capture 0x55 with i_rd_strobe=1 in the same cycle.
  - Required: o_count stays 16, head becomes 0x11, 0x55 stored last, o_overrun=0.
- Reset mid-handshake and empty pop:
  - Stimulus: assert i_reset_n=0 while in ACK.
  - Required: o_rx_rdy_ack=0 next cycle, o_count=0; a subsequent i_rd_strobe on empty leaves o_count=0 and o_empty=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Consumer side of the UART receiver. Runs the receiver's 4-phase
//   ready/ack handshake and stores every received byte in a 2**DEPTH_LOG2
//   entry synchronous FIFO. The FIFO has a show-ahead read port and reports
//   empty/full/count/overrun status to the CPU-side register logic.
//
//   This block runs on the receiver's own clock, so the handshake signals
//   need no synchronisers.
//
// Ports
//   i_uart_clk_x16    block clock, shared with the receiver
//   i_reset_n         synchronous active-low reset
//   i_rx_data         received byte, valid while i_rx_data_rdy=1
//   i_rx_data_rdy     receiver has a byte waiting
//   o_rx_rdy_ack      registered acknowledge to the receiver
//   i_rx_rdy_ack_clr  receiver acknowledges that it has seen our ack
//   i_rd_strobe       single-cycle pop request
//   o_rd_data         FIFO head (show-ahead), don't-care while empty
//   o_empty / o_full  FIFO status
//   o_count           number of stored bytes, 0..DEPTH
//   o_overrun         sticky: a byte arrived while the FIFO was full
//   i_overrun_clr     clears o_overrun
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_uart_clk_x16,
    input  logic                  i_reset_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_data_rdy,
    output logic                  o_rx_rdy_ack,
    input  logic                  i_rx_rdy_ack_clr,
    input  logic                  i_rd_strobe,
    output logic [7:0]            o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overrun,
    input  logic                  i_overrun_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    ack_reg, ack_next;
    logic                    capture;

    logic [7:0]              mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]     count_reg, count_next;
    logic                    overrun_reg;
    logic                    push, pop, drop;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_uart_clk_x16) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
        end
    end

    // A byte is captured only on the IDLE->ACK transition, so a ready that
    // stays high through ACK/WAIT_CLR is never taken twice. ACK waits for
    // ack_clr indefinitely: a receiver that resets mid-handshake simply
    // drops and later re-raises ack_clr, which still ends the handshake.
    always_comb begin
        state_next = state_reg;
        ack_next   = ack_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                ack_next = 1'b0;
                if (i_rx_data_rdy && !i_rx_rdy_ack_clr) begin
                    capture    = 1'b1;
                    ack_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                ack_next = 1'b1;
                if (i_rx_rdy_ack_clr) begin
                    ack_next   = 1'b0;
                    state_next = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                ack_next = 1'b0;
                if (!i_rx_rdy_ack_clr) begin
                    state_next = IDLE;
                end
            end
            default: begin
                ack_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // A same-cycle pop frees a slot, so a capture into a full FIFO is
    // accepted when the head leaves at the same edge. Pop on empty is
    // ignored, which also makes push+pop on empty a plain push.
    always_comb begin
        pop  = i_rd_strobe && (count_reg != '0);
        push = capture && ((count_reg != DEPTH_CNT) || pop);
        drop = capture && !push;
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_uart_clk_x16) begin
        if (!i_reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop)
                overrun_reg <= 1'b1;
            else if (i_overrun_clr)
                overrun_reg <= 1'b0;
        end
    end

    // Storage is not reset; stale bytes are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge i_uart_clk_x16) begin
        if (push) mem_reg[wr_ptr_reg] <= i_rx_data;
    end

    assign o_rd_data    = mem_reg[rd_ptr_reg];
    assign o_rx_rdy_ack = ack_reg;
    assign o_count      = count_reg;
    assign o_empty      = (count_reg == '0);
    assign o_full       = (count_reg == DEPTH_CNT);
    assign o_overrun    = overrun_reg;

endmodule
